// File: rtl/stage_decode.sv
// Decode stage: field extraction, operand fetch with X/M forwarding,
// register file and load-use restart detection.
module stage_decode (
    input  logic        clock,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_npc,
    input  logic        x_valid,
    input  logic [5:0]  x_wbr,
    input  logic [31:0] x_res,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic [5:0]  m_wbr,
    input  logic [31:0] m_res,
    input  logic        flush_D,
    output logic        d_valid,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_npc,
    output logic [5:0]  d_opcode,
    output logic [5:0]  d_fn,
    output logic [4:0]  d_rd,
    output logic [4:0]  d_sa,
    output logic [5:0]  d_rs,
    output logic [5:0]  d_rt,
    output logic [31:0] d_target,
    output logic [5:0]  d_wbr,
    output logic        d_has_delay_slot,
    output logic [31:0] d_op1_val,
    output logic [31:0] d_op2_val,
    output logic [31:0] d_rt_val,
    output logic [31:0] d_simm,
    output logic        d_restart,
    output logic [31:0] d_restart_pc,
    output logic        d_flush_X,
    output logic [31:0] perf_delay_slot_bubble,
    output logic [47:0] perf_retired_inst
);

    logic [31:0] rf [32];

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs5;
    logic [4:0]  rt5;
    logic [4:0]  rd5;
    logic [15:0] imm;
    logic [31:0] simm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] op2;
    logic [5:0]  wbr;
    logic        has_ds;
    logic        use_rt_op2;
    logic        rt_use;
    logic        link_rgm;
    logic        wr_rt;
    logic        logic_imm;
    logic        last_load;
    logic        hazard;
    logic        ds_flag;
    logic        rf_we;
    logic        unused_m_pc;

    assign op   = i_instr[31:26];
    assign fn   = i_instr[5:0];
    assign rs5  = i_instr[25:21];
    assign rt5  = i_instr[20:16];
    assign rd5  = i_instr[15:11];
    assign imm  = i_instr[15:0];
    assign simm = {{16{imm[15]}}, imm};

    assign use_rt_op2 = (op <= 6'd7)
                      || (op >= 6'd20 && op <= 6'd23);
    assign rt_use    = use_rt_op2
                     || (op >= 6'd40 && op <= 6'd46);
    assign link_rgm  = (op == 6'd1)
                     && (rt5 == 5'd16 || rt5 == 5'd17);
    assign wr_rt     = (op >= 6'd8 && op <= 6'd15)
                     || (op >= 6'd32 && op <= 6'd38);
    assign logic_imm = (op >= 6'd12 && op <= 6'd14);

    assign has_ds = (op == 6'd0 && (fn == 6'd8 || fn == 6'd9))
                  || (op >= 6'd1 && op <= 6'd7)
                  || (op >= 6'd20 && op <= 6'd23);

    // Later assignments win: X beats M beats the register file.
    always_comb begin
        rs_val = (rs5 == 5'd0) ? 32'd0 : rf[rs5];
        if (m_valid && m_wbr == {1'b0, rs5} && rs5 != 5'd0)
            rs_val = m_res;
        if (x_valid && x_wbr == {1'b0, rs5} && rs5 != 5'd0)
            rs_val = x_res;
    end

    always_comb begin
        rt_val = (rt5 == 5'd0) ? 32'd0 : rf[rt5];
        if (m_valid && m_wbr == {1'b0, rt5} && rt5 != 5'd0)
            rt_val = m_res;
        if (x_valid && x_wbr == {1'b0, rt5} && rt5 != 5'd0)
            rt_val = x_res;
    end

    always_comb begin
        wbr = 6'd0;
        unique case (1'b1)
            op == 6'd0: wbr = (fn == 6'd8) ? 6'd0 : {1'b0, rd5};
            op == 6'd3: wbr = 6'd31;
            link_rgm:   wbr = 6'd31;
            wr_rt:      wbr = {1'b0, rt5};
            default:    wbr = 6'd0;
        endcase
    end

    always_comb begin
        op2 = simm;
        unique case (1'b1)
            use_rt_op2:   op2 = rt_val;
            logic_imm:    op2 = {16'h0, imm};
            op == 6'd15:  op2 = {imm, 16'h0};
            default:      op2 = simm;
        endcase
    end

    assign last_load = d_valid && !flush_D
                     && d_opcode >= 6'd32 && d_opcode <= 6'd38;

    assign hazard = i_valid && last_load && d_wbr != 6'd0
                  && (d_wbr == {1'b0, rs5}
                      || (rt_use && d_wbr == {1'b0, rt5}));

    assign rf_we = m_valid && m_wbr != 6'd0 && !m_wbr[5];

    always_ff @(posedge clock) begin
        if (rf_we)
            rf[m_wbr[4:0]] <= m_res;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            d_valid                <= 1'b0;
            d_instr                <= '0;
            d_pc                   <= '0;
            d_npc                  <= '0;
            d_target               <= '0;
            d_wbr                  <= '0;
            d_has_delay_slot       <= 1'b0;
            d_op1_val              <= '0;
            d_op2_val              <= '0;
            d_rt_val               <= '0;
            d_simm                 <= '0;
            d_restart              <= 1'b0;
            d_restart_pc           <= '0;
            ds_flag                <= 1'b0;
            perf_delay_slot_bubble <= '0;
            perf_retired_inst      <= '0;
        end else begin
            d_valid          <= i_valid && !hazard;
            d_instr          <= i_instr;
            d_pc             <= i_pc;
            d_npc            <= i_npc;
            d_target         <= {i_npc[31:28], i_instr[25:0], 2'b00};
            d_wbr            <= wbr;
            d_has_delay_slot <= has_ds;
            d_op1_val        <= rs_val;
            d_op2_val        <= op2;
            d_rt_val         <= rt_val;
            d_simm           <= simm;
            d_restart        <= hazard;
            ds_flag          <= d_valid && d_has_delay_slot;
            // A load sitting in a delay slot restarts from its own PC.
            if (hazard)
                d_restart_pc <= ds_flag ? d_pc : i_pc;
            if (hazard && ds_flag)
                perf_delay_slot_bubble <= perf_delay_slot_bubble + 32'd1;
            if (m_valid)
                perf_retired_inst <= perf_retired_inst + 48'd1;
        end
    end

    assign d_opcode  = d_instr[31:26];
    assign d_fn      = d_instr[5:0];
    assign d_rd      = d_instr[15:11];
    assign d_sa      = d_instr[10:6];
    assign d_rs      = {1'b0, d_instr[25:21]};
    assign d_rt      = {1'b0, d_instr[20:16]};
    assign d_flush_X = 1'b0;

    assign unused_m_pc = ^m_pc;

endmodule

// File: tb/tb_stage_decode.sv
// Bench for stage_decode: decode vector table through a scoreboard queue,
// then forwarding, load-use restart, counter and reset sequences.
module tb_stage_decode;

    logic        clock = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_instr, i_pc, i_npc;
    logic        x_valid;
    logic [5:0]  x_wbr;
    logic [31:0] x_res;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [5:0]  m_wbr;
    logic [31:0] m_res;
    logic        flush_D;
    logic        d_valid;
    logic [31:0] d_instr, d_pc, d_npc;
    logic [5:0]  d_opcode, d_fn;
    logic [4:0]  d_rd, d_sa;
    logic [5:0]  d_rs, d_rt;
    logic [31:0] d_target;
    logic [5:0]  d_wbr;
    logic        d_has_delay_slot;
    logic [31:0] d_op1_val, d_op2_val, d_rt_val, d_simm;
    logic        d_restart;
    logic [31:0] d_restart_pc;
    logic        d_flush_X;
    logic [31:0] perf_delay_slot_bubble;
    logic [47:0] perf_retired_inst;

    stage_decode dut (
        .clock(clock), .rst(rst),
        .i_valid(i_valid), .i_instr(i_instr),
        .i_pc(i_pc), .i_npc(i_npc),
        .x_valid(x_valid), .x_wbr(x_wbr), .x_res(x_res),
        .m_valid(m_valid), .m_pc(m_pc),
        .m_wbr(m_wbr), .m_res(m_res),
        .flush_D(flush_D),
        .d_valid(d_valid), .d_instr(d_instr),
        .d_pc(d_pc), .d_npc(d_npc),
        .d_opcode(d_opcode), .d_fn(d_fn),
        .d_rd(d_rd), .d_sa(d_sa),
        .d_rs(d_rs), .d_rt(d_rt),
        .d_target(d_target), .d_wbr(d_wbr),
        .d_has_delay_slot(d_has_delay_slot),
        .d_op1_val(d_op1_val), .d_op2_val(d_op2_val),
        .d_rt_val(d_rt_val), .d_simm(d_simm),
        .d_restart(d_restart), .d_restart_pc(d_restart_pc),
        .d_flush_X(d_flush_X),
        .perf_delay_slot_bubble(perf_delay_slot_bubble),
        .perf_retired_inst(perf_retired_inst)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [5:0]  wbr;
        logic        ds;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] rtv;
        logic [31:0] simm;
        logic        tc;
        logic [31:0] tgt;
    } vec_t;

    vec_t tab [16];
    vec_t sbq [$];
    vec_t e;

    int n_chk  = 0;
    int n_fail = 0;
    logic [47:0] exp_ret = '0;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic v, input logic [31:0] instr,
        input logic [31:0] pc, input logic [31:0] npc,
        input logic [5:0] wbr, input logic ds,
        input logic [31:0] op1, input logic [31:0] op2,
        input logic [31:0] rtv, input logic [31:0] simm,
        input logic tc, input logic [31:0] tgt);
        vec_t r;
        r.v = v; r.instr = instr; r.pc = pc; r.npc = npc;
        r.wbr = wbr; r.ds = ds; r.op1 = op1; r.op2 = op2;
        r.rtv = rtv; r.simm = simm; r.tc = tc; r.tgt = tgt;
        return r;
    endfunction

    task automatic cycle();
        if (rst && m_valid)
            exp_ret = exp_ret + 48'd1;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr,
                         input logic [31:0] pc, input logic [31:0] npc);
        i_valid = v;
        i_instr = instr;
        i_pc    = pc;
        i_npc   = npc;
    endtask

    task automatic set_m(input logic v, input logic [5:0] w,
                         input logic [31:0] r);
        m_valid = v;
        m_wbr   = w;
        m_res   = r;
        m_pc    = 32'hC0DE_0000;
    endtask

    task automatic set_x(input logic v, input logic [5:0] w,
                         input logic [31:0] r);
        x_valid = v;
        x_wbr   = w;
        x_res   = r;
    endtask

    initial begin
        // Register k is preloaded with k*17.
        tab[0]  = mk(1, 32'h24020005, 32'h100, 32'h104, 6'd2, 0,
                     32'h0, 32'h5, 32'h22, 32'h5, 0, 32'h0);
        tab[1]  = mk(1, 32'h00632021, 32'h104, 32'h108, 6'd4, 0,
                     32'h33, 32'h33, 32'h33, 32'h2021, 0, 32'h0);
        tab[2]  = mk(1, 32'h08400040, 32'h80000000, 32'h80000004,
                     6'd0, 1, 32'h22, 32'h0, 32'h0, 32'h40,
                     1, 32'h81000100);
        tab[3]  = mk(1, 32'h0C000010, 32'h00400004, 32'h00400008,
                     6'd31, 1, 32'h0, 32'h0, 32'h0, 32'h10,
                     1, 32'h40);
        tab[4]  = mk(1, 32'h00600008, 32'h100, 32'h104, 6'd0, 1,
                     32'h33, 32'h0, 32'h0, 32'h8, 1, 32'h01800020);
        tab[5]  = mk(1, 32'h0060F809, 32'h104, 32'h108, 6'd31, 1,
                     32'h33, 32'h0, 32'h0, 32'hFFFFF809, 0, 32'h0);
        tab[6]  = mk(1, 32'h3027F00F, 32'h108, 32'h10C, 6'd7, 0,
                     32'h11, 32'h0000F00F, 32'h77, 32'hFFFFF00F,
                     0, 32'h0);
        tab[7]  = mk(1, 32'h3C08ABCD, 32'h10C, 32'h110, 6'd8, 0,
                     32'h0, 32'hABCD0000, 32'h88, 32'hFFFFABCD,
                     0, 32'h0);
        tab[8]  = mk(1, 32'h04310010, 32'h110, 32'h114, 6'd31, 1,
                     32'h11, 32'h121, 32'h121, 32'h10, 0, 32'h0);
        tab[9]  = mk(1, 32'h04400008, 32'h114, 32'h118, 6'd0, 1,
                     32'h22, 32'h0, 32'h0, 32'h8, 0, 32'h0);
        tab[10] = mk(1, 32'hAC250004, 32'h118, 32'h11C, 6'd0, 0,
                     32'h11, 32'h4, 32'h55, 32'h4, 0, 32'h0);
        tab[11] = mk(1, 32'h8C49FFFC, 32'h11C, 32'h120, 6'd9, 0,
                     32'h22, 32'hFFFFFFFC, 32'h99, 32'hFFFFFFFC,
                     0, 32'h0);
        tab[12] = mk(1, 32'h10220003, 32'h120, 32'h124, 6'd0, 1,
                     32'h11, 32'h22, 32'h22, 32'h3, 0, 32'h0);
        tab[13] = mk(1, 32'h50630001, 32'h124, 32'h128, 6'd0, 1,
                     32'h33, 32'h33, 32'h33, 32'h1, 0, 32'h0);
        tab[14] = mk(1, 32'h340A8000, 32'h128, 32'h12C, 6'd10, 0,
                     32'h0, 32'h8000, 32'hAA, 32'hFFFF8000, 0, 32'h0);
        tab[15] = mk(0, 32'h00632021, 32'h12C, 32'h130, 6'd0, 0,
                     32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0);

        rst = 1'b0;
        flush_D = 1'b0;
        set_x(0, 6'd0, 32'h0);
        set_m(1, 6'd0, 32'h0);
        drive(1, 32'h24020005, 32'h100, 32'h104);
        repeat (3) cycle();
        chk("rst_d_valid", d_valid, 1'b0);
        chk("rst_d_restart", d_restart, 1'b0);
        chk("rst_restart_pc", d_restart_pc, 32'h0);
        chk("rst_d_pc", d_pc, 32'h0);
        chk("rst_d_wbr", d_wbr, 6'd0);
        chk("rst_op2", d_op2_val, 32'h0);
        chk("rst_retired", perf_retired_inst, 48'd0);
        chk("rst_bubble", perf_delay_slot_bubble, 32'd0);
        chk("rst_flush_x", d_flush_X, 1'b0);

        set_m(0, 6'd0, 32'h0);
        rst = 1'b1;
        cycle();
        chk("first_valid", d_valid, 1'b1);
        chk("addiu_wbr", d_wbr, 6'd2);
        chk("addiu_op1", d_op1_val, 32'h0);
        chk("addiu_op2", d_op2_val, 32'h5);
        chk("addiu_simm", d_simm, 32'h5);
        chk("addiu_pc", d_pc, 32'h100);

        drive(0, 32'h0, 32'h0, 32'h0);
        for (int k = 1; k < 32; k++) begin
            set_m(1, 6'(k), 32'(k * 17));
            cycle();
        end
        set_m(1, 6'h21, 32'h0BAD);
        cycle();
        set_m(0, 6'd0, 32'h0);

        for (int i = 0; i < 16; i++) begin
            drive(tab[i].v, tab[i].instr, tab[i].pc, tab[i].npc);
            sbq.push_back(tab[i]);
            cycle();
            e = sbq.pop_front();
            chk($sformatf("v%0d_valid", i), d_valid, e.v);
            if (e.v) begin
                chk($sformatf("v%0d_pc", i), d_pc, e.pc);
                chk($sformatf("v%0d_opcode", i), d_opcode,
                    {58'd0, e.instr[31:26]});
                chk($sformatf("v%0d_rs", i), d_rs,
                    {59'd0, e.instr[25:21]});
                chk($sformatf("v%0d_wbr", i), d_wbr, e.wbr);
                chk($sformatf("v%0d_ds", i), d_has_delay_slot, e.ds);
                chk($sformatf("v%0d_op1", i), d_op1_val, e.op1);
                chk($sformatf("v%0d_op2", i), d_op2_val, e.op2);
                chk($sformatf("v%0d_rtv", i), d_rt_val, e.rtv);
                chk($sformatf("v%0d_simm", i), d_simm, e.simm);
                chk($sformatf("v%0d_restart", i), d_restart, 1'b0);
                if (e.tc)
                    chk($sformatf("v%0d_tgt", i), d_target, e.tgt);
            end
        end

        drive(1, 32'h00632021, 32'h400, 32'h404);
        set_m(1, 6'd3, 32'hDEAD);
        cycle();
        chk("fwd_m_op1", d_op1_val, 32'hDEAD);
        chk("fwd_m_op2", d_op2_val, 32'hDEAD);
        set_m(1, 6'd3, 32'hBEEF);
        set_x(1, 6'd3, 32'h1234);
        cycle();
        chk("fwd_x_op1", d_op1_val, 32'h1234);
        chk("fwd_x_op2", d_op2_val, 32'h1234);
        set_m(0, 6'd0, 32'h0);
        set_x(1, 6'h23, 32'h7777);
        cycle();
        chk("rf_after_m_write", d_op1_val, 32'hBEEF);
        set_x(1, 6'd0, 32'h5555);
        set_m(1, 6'd0, 32'h6666);
        drive(1, 32'h00002021, 32'h408, 32'h40C);
        cycle();
        chk("r0_no_fwd_op1", d_op1_val, 32'h0);
        chk("r0_no_fwd_op2", d_op2_val, 32'h0);
        set_x(0, 6'd0, 32'h0);
        set_m(0, 6'd0, 32'h0);

        drive(1, 32'h8C250000, 32'h204, 32'h208);
        cycle();
        chk("lw_valid", d_valid, 1'b1);
        chk("lw_wbr", d_wbr, 6'd5);
        drive(1, 32'h00A03021, 32'h208, 32'h20C);
        cycle();
        chk("lu_rs_valid", d_valid, 1'b0);
        chk("lu_rs_restart", d_restart, 1'b1);
        chk("lu_rs_pc", d_restart_pc, 32'h208);
        drive(0, 32'h0, 32'h0, 32'h0);
        cycle();
        chk("lu_one_cycle", d_restart, 1'b0);
        chk("lu_no_bubble", perf_delay_slot_bubble, 32'd0);

        drive(1, 32'h8C250000, 32'h20C, 32'h210);
        cycle();
        drive(1, 32'hAC250000, 32'h210, 32'h214);
        cycle();
        chk("lu_rt_restart", d_restart, 1'b1);
        chk("lu_rt_valid", d_valid, 1'b0);
        chk("lu_rt_pc", d_restart_pc, 32'h210);

        drive(1, 32'h8C250000, 32'h220, 32'h224);
        cycle();
        drive(1, 32'h24250001, 32'h224, 32'h228);
        cycle();
        chk("nolu_rt_valid", d_valid, 1'b1);
        chk("nolu_rt_restart", d_restart, 1'b0);

        drive(1, 32'h8C250000, 32'h230, 32'h234);
        cycle();
        drive(1, 32'h00A03021, 32'h234, 32'h238);
        flush_D = 1'b1;
        cycle();
        flush_D = 1'b0;
        chk("flush_restart", d_restart, 1'b0);
        chk("flush_valid", d_valid, 1'b1);

        drive(1, 32'h8C200000, 32'h240, 32'h244);
        cycle();
        drive(1, 32'h00003021, 32'h244, 32'h248);
        cycle();
        chk("lw_r0_restart", d_restart, 1'b0);
        chk("lw_r0_valid", d_valid, 1'b1);

        drive(1, 32'h10220003, 32'h300, 32'h304);
        cycle();
        drive(1, 32'h8C250000, 32'h304, 32'h308);
        cycle();
        drive(1, 32'h00A03021, 32'h308, 32'h30C);
        cycle();
        chk("ds_restart", d_restart, 1'b1);
        chk("ds_valid", d_valid, 1'b0);
        chk("ds_restart_pc", d_restart_pc, 32'h304);
        chk("ds_bubble", perf_delay_slot_bubble, 32'd1);
        drive(0, 32'h0, 32'h0, 32'h0);
        cycle();
        chk("ds_one_cycle", d_restart, 1'b0);

        chk("retired_total", perf_retired_inst, exp_ret);

        drive(1, 32'h00632021, 32'h500, 32'h504);
        set_m(1, 6'd0, 32'h0);
        cycle();
        rst = 1'b0;
        #1;
        chk("midrst_valid", d_valid, 1'b0);
        chk("midrst_pc", d_pc, 32'h0);
        chk("midrst_op1", d_op1_val, 32'h0);
        chk("midrst_restart_pc", d_restart_pc, 32'h0);
        chk("midrst_retired", perf_retired_inst, 48'd0);
        chk("midrst_bubble", perf_delay_slot_bubble, 32'd0);
        cycle();
        rst = 1'b1;
        repeat (3) cycle();
        chk("post_rst_valid", d_valid, 1'b1);
        chk("retired_three", perf_retired_inst, 48'd3);
        set_m(0, 6'd0, 32'h0);
        cycle();
        chk("retired_hold", perf_retired_inst, 48'd3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
